// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with any depth, occupancy count and
// almost-full/almost-empty thresholds. Also has FWFT or registered
// read mode, flush, and sticky overflow/underflow flags.
// Ports: clk, reset (sync, active-high), flush, clr_err,
//        wr_req/wr_data/full/almost_full,
//        rd_req/rd_data/empty/almost_empty, count, overflow, underflow.
module sync_fifo #(
    parameter int DW     = 8,
    parameter int Length = 32,
    parameter int FWFT   = 0,
    parameter int AFThr  = Length - 1,
    parameter int AEThr  = 1,
    localparam int CW    = $clog2(Length + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          clr_err,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          almost_full,
    input  logic          rd_req,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);
    localparam int PW = $clog2(Length);
    localparam logic [PW-1:0] LastPtr = PW'(Length - 1);

    logic [DW-1:0] r_mem [Length];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_af;
    logic          r_ae;
    logic          r_ovf;
    logic          r_unf;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [CW-1:0] w_cnt_nxt;

    // Acceptance uses the registered flags only, so no request
    // reaches an output combinationally.
    always_comb begin
        w_wr_acc  = wr_req & ~r_full;
        w_rd_acc  = rd_req & ~r_empty;
        w_cnt_nxt = r_count;
        if (reset | flush) begin
            w_cnt_nxt = '0;
        end else if (w_wr_acc & ~w_rd_acc) begin
            w_cnt_nxt = r_count + CW'(1);
        end else if (w_rd_acc & ~w_wr_acc) begin
            w_cnt_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= r_ovf & ~clr_err;
            r_unf    <= r_unf & ~clr_err;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PW'(1);
            end
            // A new error outranks a coincident clear.
            r_ovf <= (wr_req & r_full) | (r_ovf & ~clr_err);
            r_unf <= (rd_req & r_empty) | (r_unf & ~clr_err);
        end
        // Flags follow the next count, so they match count every cycle.
        r_count <= w_cnt_nxt;
        r_full  <= (w_cnt_nxt == CW'(Length));
        r_empty <= (w_cnt_nxt == '0);
        r_af    <= (w_cnt_nxt >= CW'(AFThr));
        r_ae    <= (w_cnt_nxt <= CW'(AEThr));
    end

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (~reset & ~flush & w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is driven straight from storage.
            assign rd_data = r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [DW-1:0] r_rd_data;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_data <= '0;
                end else if (~flush & w_rd_acc) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                end
            end
            assign rd_data = r_rd_data;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scenario tasks for sync_fifo, Length=5, AFThr=4,
// AEThr=1; u0 is registered-read, u1 is first-word-fall-through.
module tb_sync_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, fl0 = 1'b0, clr0 = 1'b0;
    logic       wr0 = 1'b0, rd0 = 1'b0;
    logic [7:0] wd0 = '0;
    logic       full0, af0, empty0, ae0, ovf0, unf0;
    logic [7:0] rdd0;
    logic [2:0] cnt0;

    logic       rst1 = 1'b1, fl1 = 1'b0, clr1 = 1'b0;
    logic       wr1 = 1'b0, rd1 = 1'b0;
    logic [7:0] wd1 = '0;
    logic       full1, af1, empty1, ae1, ovf1, unf1;
    logic [7:0] rdd1;
    logic [2:0] cnt1;

    sync_fifo #(.DW(8), .Length(5), .FWFT(0), .AFThr(4), .AEThr(1)) u0 (
        .clk(clk), .reset(rst0), .flush(fl0), .clr_err(clr0),
        .wr_req(wr0), .wr_data(wd0), .full(full0), .almost_full(af0),
        .rd_req(rd0), .rd_data(rdd0), .empty(empty0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0),
        .underflow(unf0)
    );

    sync_fifo #(.DW(8), .Length(5), .FWFT(1), .AFThr(4), .AEThr(1)) u1 (
        .clk(clk), .reset(rst1), .flush(fl1), .clr_err(clr1),
        .wr_req(wr1), .wr_data(wd1), .full(full1), .almost_full(af1),
        .rd_req(rd1), .rd_data(rdd1), .empty(empty1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1),
        .underflow(unf1)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] e_rd = '0;
    logic       e_ovf = 1'b0;
    logic       e_unf = 1'b0;

    // Drive one cycle on u0 and advance the reference queue.
    task automatic step0(input logic wr, input logic [7:0] wd,
                         input logic rd, input logic clr, input logic fl);
        logic aw, ar;
        wr0 = wr; wd0 = wd; rd0 = rd; clr0 = clr; fl0 = fl;
        aw = wr && (q0.size() < 5) && !fl;
        ar = rd && (q0.size() > 0) && !fl;
        e_ovf = (!fl && wr && q0.size() == 5) || (e_ovf && !clr);
        e_unf = (!fl && rd && q0.size() == 0) || (e_unf && !clr);
        if (fl) begin
            q0.delete();
        end else begin
            if (ar) e_rd = q0.pop_front();
            if (aw) q0.push_back(wd);
        end
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0; fl0 = 1'b0;
    endtask

    task automatic reset0(input logic wr);
        rst0 = 1'b1; wr0 = wr; wd0 = 8'hEE;
        q0.delete(); e_rd = '0; e_ovf = 1'b0; e_unf = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b0; wr0 = 1'b0;
    endtask

    task automatic test_reset();
        reset0(1'b0);
        n_checks++;
        if ({full0, empty0, cnt0, af0, ae0, ovf0, unf0} !== 9'b0_1_000_0_1_0_0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 010000100",
                     {full0, empty0, cnt0, af0, ae0, ovf0, unf0});
        end
        n_checks++;
        if (rdd0 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rd_data got %h want 00", rdd0);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            step0(1'b1, 8'(i * 17), 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (cnt0 !== 3'(i) || ae0 !== (i <= 1) || af0 !== (i >= 4)
                || full0 !== (i == 5) || empty0 !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d got cnt=%0d ae=%b af=%b full=%b empty=%b",
                         i, cnt0, ae0, af0, full0, empty0);
            end
        end
        step0(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf0 !== 1'b1 || cnt0 !== 3'd5 || full0 !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_overflow got ovf=%b cnt=%0d full=%b want 1 5 1",
                     ovf0, cnt0, full0);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 5; i++) begin
            step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (rdd0 !== 8'(i * 17) || rdd0 !== e_rd
                || cnt0 !== 3'(5 - i) || empty0 !== (i == 5)) begin
                n_fail++;
                $display("FAIL drain_%0d got data=%h cnt=%0d empty=%b want data=%h",
                         i, rdd0, cnt0, empty0, 8'(i * 17));
            end
        end
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (unf0 !== 1'b1 || rdd0 !== 8'h55 || cnt0 !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_underflow got unf=%b data=%h cnt=%0d want 1 55 0",
                     unf0, rdd0, cnt0);
        end
    endtask

    task automatic test_wrap();
        step0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_err got ovf=%b unf=%b want 0 0", ovf0, unf0);
        end
        for (int i = 1; i <= 3; i++) step0(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step0(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (rdd0 !== e_rd || cnt0 !== 3'd3 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_%0d got data=%h cnt=%0d ovf=%b unf=%b want data=%h cnt=3",
                         i, rdd0, cnt0, ovf0, unf0, e_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset0(1'b0);
        for (int i = 1; i <= 5; i++) step0(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (cnt0 !== 3'd4 || ovf0 !== 1'b1 || rdd0 !== 8'hB1) begin
            n_fail++;
            $display("FAIL full_rdwr got cnt=%0d ovf=%b data=%h want 4 1 b1",
                     cnt0, ovf0, rdd0);
        end
        step0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", ovf0);
        end
        for (int i = 0; i < 4; i++) begin
            step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (rdd0 !== e_rd) begin
                n_fail++;
                $display("FAIL b2b_drain_%0d got %h want %h", i, rdd0, e_rd);
            end
        end
        step0(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (cnt0 !== 3'd1 || unf0 !== 1'b1 || empty0 !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rdwr got cnt=%0d unf=%b empty=%b want 1 1 0",
                     cnt0, unf0, empty0);
        end
        step0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (unf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL unf_clear got %b want 0", unf0);
        end
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (rdd0 !== 8'h99 || empty0 !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_rdwr_data got %h empty=%b want 99 1", rdd0, empty0);
        end
    endtask

    task automatic test_fwft();
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        q1.delete();
        wr1 = 1'b1; wd1 = 8'hA5; q1.push_back(8'hA5);
        @(posedge clk); #1;
        wr1 = 1'b0;
        n_checks++;
        if (empty1 !== 1'b0 || rdd1 !== q1[0] || cnt1 !== 3'd1) begin
            n_fail++;
            $display("FAIL fwft_head got empty=%b data=%h cnt=%0d want 0 a5 1",
                     empty1, rdd1, cnt1);
        end
        rd1 = 1'b1;
        void'(q1.pop_front());
        @(posedge clk); #1;
        rd1 = 1'b0;
        n_checks++;
        if (empty1 !== 1'b1 || cnt1 !== 3'd0) begin
            n_fail++;
            $display("FAIL fwft_pop got empty=%b cnt=%0d want 1 0", empty1, cnt1);
        end
        for (int i = 0; i < 2; i++) begin
            wr1 = 1'b1; wd1 = (i == 0) ? 8'h3C : 8'h5A; q1.push_back(wd1);
            @(posedge clk); #1;
        end
        wr1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (empty1 !== 1'b0 || rdd1 !== q1[0]) begin
                n_fail++;
                $display("FAIL fwft_seq_%0d got data=%h empty=%b want %h",
                         i, rdd1, empty1, q1[0]);
            end
            rd1 = 1'b1;
            void'(q1.pop_front());
            @(posedge clk); #1;
            rd1 = 1'b0;
        end
        n_checks++;
        if (empty1 !== 1'b1) begin
            n_fail++;
            $display("FAIL fwft_final_empty got %b want 1", empty1);
        end
    endtask

    task automatic test_flush_reset();
        reset0(1'b0);
        for (int i = 1; i <= 5; i++) step0(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step0(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step0(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({full0, empty0, cnt0, af0, ae0, ovf0} !== 8'b0_1_000_0_1_1
            || rdd0 !== 8'hC2) begin
            n_fail++;
            $display("FAIL flush got flags=%b data=%h want 01000011 c2",
                     {full0, empty0, cnt0, af0, ae0, ovf0}, rdd0);
        end
        for (int i = 1; i <= 3; i++) step0(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (cnt0 !== 3'd3 || ovf0 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_flush got cnt=%0d ovf=%b want 3 1", cnt0, ovf0);
        end
        reset0(1'b1);
        n_checks++;
        if ({full0, empty0, cnt0, af0, ae0, ovf0, unf0} !== 9'b0_1_000_0_1_0_0
            || rdd0 !== 8'h00) begin
            n_fail++;
            $display("FAIL midop_reset got flags=%b data=%h want 010000100 00",
                     {full0, empty0, cnt0, af0, ae0, ovf0, unf0}, rdd0);
        end
        step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (unf0 !== 1'b1 || cnt0 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_write_ignored got unf=%b cnt=%0d want 1 0",
                     unf0, cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_fwft();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock FIFO with parameterised data width and arbitrary (non-power-of-2) depth. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) read mode, flush, and sticky overflow/underflow error flags. It is the general-purpose buffer for same-clock producer/consumer paths, where clock-domain crossing is not needed.

## Interface
Parameters:
- DW, 8, data width in bits (≥1).
- Length, 32, capacity in words; any integer ≥2, used exactly, no rounding to a power of 2.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AFThr, Length-1, almost_full asserted when count ≥ AFThr; legal range 1..Length.
- AEThr, 1, almost_empty asserted when count ≤ AEThr; legal range 0..Length-1.
- CW (localparam), NumBits(Length+1), width of count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all contents.
- clr_err  in  1  clears overflow/underflow.
- wr_req  in  1  write request.
- wr_data  in  DW  write data.
- full  out  1  count == Length.
- almost_full  out  1  count ≥ AFThr.
- rd_req  in  1  read request (pop in FWFT mode).
- rd_data  out  DW  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AEThr.
- count  out  CW  current occupancy, 0..Length.
- overflow  out  1  sticky: write requested while full.
- underflow  out  1  sticky: read requested while empty.

## Operation
- Accept conditions are evaluated on flag values at the start of the cycle: write accepted = wr_req & ~full; read accepted = rd_req & ~empty.
- Write and read pointers run 0..Length-1 and wrap from Length-1 to 0, independently of whether Length is a power of 2.
- Count update per cycle:
  - write only: count+1.
  - read only: count-1.
  - both or neither: count unchanged.
- full, empty, almost_full and almost_empty are registered and derived from the next count value, so they always match count in the same cycle.
- FWFT=0: on an accepted read, rd_data loads mem[rdPtr] at the edge; otherwise rd_data holds its value.
- FWFT=1: rd_data shows the head word, mem[rdPtr], whenever empty=0. An accepted rd_req pops it, and the next word appears after the edge. rd_data is don't-care while empty=1.
- Errors:
  - overflow is set on wr_req & full; the write is dropped and storage is unchanged.
  - underflow is set on rd_req & empty; the read is ignored, and in FWFT=0 rd_data holds.
- Error flags clear only on reset or clr_err. If clr_err coincides with a new error, the error wins and the flag stays 1.
- Simultaneous rd_req and wr_req:
  - when full: the read is accepted, the write is dropped and overflow is set; count becomes Length-1.
  - when empty: the write is accepted, the read is rejected and underflow is set; count becomes 1.
- flush:
  - pointers and count go to 0, empty=1, full=0, almost flags are recomputed for count 0.
  - wr_req and rd_req in the same cycle are ignored and raise no errors.
  - overflow, underflow and rd_data are preserved.
- Priority: reset > flush > normal operation.

## Timing
- Reset values (after the edge where reset=1): full=0, empty=1, count=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, rd_data=0. Memory contents are not cleared.
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored.
- Write to empty deassert: 1 cycle. A write accepted at edge N gives empty=0 after edge N, and in FWFT=1 rd_data is valid in that same cycle.
- Read latency, FWFT=0: 1 cycle; data is valid after the edge that accepted the read.
- Read latency, FWFT=1: 0 cycles; the head word is present before rd_req is asserted.
- Read to full deassert: 1 cycle.
- Sustained throughput: one write and one read per cycle, including at pointer wrap.
- No combinational path from wr_req or rd_req to any output. In FWFT=1 there is a path from storage to rd_data only.

## Test plan
All scenarios use DW=8, Length=5, AFThr=4, AEThr=1.
- Reset then fill: write 0x11..0x55 in consecutive cycles. Required: count steps 1..5; almost_empty drops at count 2; almost_full rises at count 4; full=1 after the 5th write. A 6th write sets overflow=1, count stays 5, and storage is unchanged.
- Drain with FWFT=0: read 5 times. Required: rd_data gives 0x11..0x55, each one cycle after its read is accepted; empty=1 after the 5th read. A 6th read sets underflow=1 and rd_data holds 0x55.
- Wrap-around: run 12 cycles of simultaneous read and write at count 3. Required: count stays 3, data comes out in order across pointer wrap 4→0, and no error flags are set.
- Simultaneous requests at the boundaries. At full, rd+wr: count becomes 4 and overflow=1. At empty, rd+wr: count becomes 1 and underflow=1. In the same cycle as an error, clr_err=1: the flag stays 1. A later clr_err alone clears it.
- FWFT=1: write 0xA5 to an empty FIFO. Required: in the next cycle empty=0 and rd_data=0xA5 with no rd_req; rd_req pops it and empty=1 on the following cycle.
- flush and reset at count 3 with overflow=1 and wr_req=1. flush: count=0, empty=1, overflow stays 1, the write is ignored. reset: all outputs take their reset values and overflow=0.
